regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file for the pipelined MIPS datapath: two combinational read ports and one synchronous write port.
- Configurable data width and depth, optional hardwired-zero register 0, and optional write-to-read bypass.
- Per-register pending-write scoreboard so the hazard unit can stall on unresolved producers.
- Sequential clear engine that zeroes the array one entry per cycle without asserting reset.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked pending.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- we  input  1  write enable (writeback).
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- issue_en  input  1  instruction issued that will write issue_rd.
- issue_rd  input  ADDR_W  destination of the issued instruction.
- busy1  output  1  ra1 has an outstanding pending write.
- busy2  output  1  ra2 has an outstanding pending write.
- clr_req  input  1  single-cycle pulse requesting a full array clear.
- clr_busy  output  1  clear sweep in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - All NUM_REGS entries are 0; all pending bits are 0.
  - FSM is IDLE, sweep index is 0, clr_busy=0.
  - rd1/rd2 therefore read 0 and busy1/busy2 read 0.
- Read path:
  - rdN = array[raN].
  - If ZERO_REG=1 and raN==0, rdN=0 unconditionally.
  - If BYPASS=1, FSM is IDLE, we=1, wa==raN and the write is not suppressed by ZERO_REG, then rdN=wd.
  - Zero latency.
- Write:
  - In IDLE, on posedge with we=1, array[wa] <= wd.
  - When ZERO_REG=1 and wa==0, the write is dropped.
- Scoreboard:
  - In IDLE, issue_en=1 sets pend[issue_rd] at the next edge; we=1 clears pend[wa] at the next edge.
  - If issue_en and we target the same register in the same cycle, set wins: a new producer supersedes the old one.
  - With ZERO_REG=1, issue_rd==0 is ignored.
  - busyN = pend[raN], except busyN=0 when BYPASS=1 and the same-cycle write to raN is forwarded.
  - With ZERO_REG=1 and raN==0, busyN=0.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1; index is set to 0.
  - In SWEEP, on each edge array[index] <= 0 and pend[index] <= 0, then index++.
  - After entry NUM_REGS-1 is written, return to IDLE.
  - Sweep lasts exactly NUM_REGS cycles; clr_busy=1 for exactly those cycles.
  - In SWEEP, we and issue_en are ignored: the requester must hold off while clr_busy=1, and dropped writes are not queued.
  - In SWEEP, bypass is disabled and reads return the live array contents, so already-swept entries read 0.
  - clr_req while in SWEEP is ignored and does not restart the sweep.
  - If clr_req and we arrive in the same IDLE cycle, the write commits and the sweep starts next cycle, so that entry is cleared later in the sweep.
- Reset mid-sweep: immediate return to the reset state; no partial sweep resumes.
- Address arithmetic: index is ADDR_W+1 bits wide so the terminal count NUM_REGS-1 is detected without wrap ambiguity. Addresses are unsigned and there is no out-of-range case.

Test Plan:
- Reset then read: hold reset=0, write attempts with we=1 -> every ra1/ra2 in 0..31 reads 0 and busy1=busy2=0; after release, write reg 5=0xDEADBEEF -> next cycle rd1(ra1=5)=0xDEADBEEF.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF, issue_en=1, issue_rd=0 -> rd1(ra1=0)=0 and busy1=0 on the same cycle and every later cycle.
- Bypass: reg 7 holds 0x11; in one cycle we=1, wa=7, wd=0x22, ra1=7, ra2=7 -> rd1=rd2=0x22 and busy1=0 in that cycle; with BYPASS=0 the same stimulus gives rd1=0x11 that cycle and 0x22 the next.
- Scoreboard: issue_en, issue_rd=9 -> next cycle busy1(ra1=9)=1. Same cycle issue_rd=9 and we, wa=9 -> pending stays 1. Lone we, wa=9 -> next cycle busy1=0.
- Clear sweep: fill regs 1..31 with nonzero values and set pend[3], pulse clr_req -> clr_busy=1 for exactly 32 cycles. A we=1 to reg 4 mid-sweep is dropped. Afterwards all regs read 0, busy=0, clr_busy=0.
- Reset mid-sweep: pulse clr_req, assert reset=0 at sweep cycle 10 -> clr_busy=0 asynchronously and all regs read 0. After release, a normal write to reg 2=0x5 reads back 0x5.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/scoreboard/clear signal bundle for regfile_scoreboard
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              busy1;
  logic              busy2;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output ra1, ra2, we, wa, wd, issue_en, issue_rd, clr_req,
    input  rd1, rd2, busy1, busy2, clr_busy
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, issue_en, issue_rd, clr_req,
    output rd1, rd2, busy1, busy2, clr_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R1W register file with pending-write scoreboard and sweep clear
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  logic wr_ok;
  logic iss_ok;
  logic fwd;

  assign wr_ok  = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
  assign iss_ok = bus.issue_en && !((ZERO_REG != 0) && (bus.issue_rd == '0));
  // No forwarding while in reset: nothing is actually being written then.
  assign fwd    = (BYPASS != 0) && reset && (state == IDLE) && wr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clr_req) state_next = SWEEP;
      SWEEP:   if (idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.clr_busy = (state == SWEEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      pend <= '0;
      idx  <= '0;
    end else if (state == SWEEP) begin
      mem[idx[ADDR_W-1:0]]  <= '0;
      pend[idx[ADDR_W-1:0]] <= 1'b0;
      idx                   <= idx + 1'b1;
    end else begin
      idx <= '0;
      if (wr_ok) begin
        mem[bus.wa]  <= bus.wd;
        pend[bus.wa] <= 1'b0;
      end
      // Issued after the clear above so a new producer wins over a retiring one.
      if (iss_ok) pend[bus.issue_rd] <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] ra [2];
  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] data;
    logic              busy;
    always_comb begin
      data = mem[ra[p]];
      busy = pend[ra[p]];
      if (fwd && (bus.wa == ra[p])) begin
        data = bus.wd;
        busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra[p] == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end
  end

  assign bus.rd1   = g_rd[0].data;
  assign bus.rd2   = g_rd[1].data;
  assign bus.busy1 = g_rd[0].busy;
  assign bus.busy2 = g_rd[1].busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard (bypass and no-bypass builds)
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, issue_rd = '0;
  logic [31:0] wd = '0;
  logic we = 1'b0, issue_en = 1'b0, clr_req = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) nb_bus ();

  assign bus.ra1 = ra1;        assign nb_bus.ra1 = ra1;
  assign bus.ra2 = ra2;        assign nb_bus.ra2 = ra2;
  assign bus.we = we;          assign nb_bus.we = we;
  assign bus.wa = wa;          assign nb_bus.wa = wa;
  assign bus.wd = wd;          assign nb_bus.wd = wd;
  assign bus.issue_en = issue_en; assign nb_bus.issue_en = issue_en;
  assign bus.issue_rd = issue_rd; assign nb_bus.issue_rd = issue_rd;
  assign bus.clr_req = clr_req;   assign nb_bus.clr_req = clr_req;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .bus(nb_bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'hAAAA_AAAA;
    issue_en = 1'b1; issue_rd = 5'd5;
    step(); step();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check("rst_rd1", bus.rd1, 0);
      check("rst_rd2", bus.rd2, 0);
      check("rst_busy1", bus.busy1, 0);
      check("rst_busy2", bus.busy2, 0);
    end
    check("rst_clr_busy", bus.clr_busy, 0);

    reset = 1'b1;
    issue_en = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    step();
    we = 1'b0; ra1 = 5'd5;
    #1 check("wr5_rd1", bus.rd1, 32'hDEAD_BEEF);

    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5'd0; ra1 = 5'd0;
    #1;
    check("zero_rd1_same", bus.rd1, 0);
    check("zero_busy1_same", bus.busy1, 0);
    step();
    we = 1'b0; issue_en = 1'b0;
    #1;
    check("zero_rd1_next", bus.rd1, 0);
    check("zero_busy1_next", bus.busy1, 0);
    check("zero_nb_rd1", nb_bus.rd1, 0);
    check("zero_nb_busy1", nb_bus.busy1, 0);

    we = 1'b1; wa = 5'd7; wd = 32'h11;
    step();
    we = 1'b0; issue_en = 1'b1; issue_rd = 5'd7;
    step();
    issue_en = 1'b0;
    we = 1'b1; wa = 5'd7; wd = 32'h22; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check("byp_rd1", bus.rd1, 32'h22);
    check("byp_rd2", bus.rd2, 32'h22);
    check("byp_busy1", bus.busy1, 0);
    check("nb_rd1_same", nb_bus.rd1, 32'h11);
    check("nb_busy1_same", nb_bus.busy1, 1);
    step();
    we = 1'b0;
    #1;
    check("nb_rd1_next", nb_bus.rd1, 32'h22);
    check("nb_busy1_next", nb_bus.busy1, 0);
    check("byp_rd1_next", bus.rd1, 32'h22);

    issue_en = 1'b1; issue_rd = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
    step();
    #1;
    check("sb_busy1_set", bus.busy1, 1);
    check("sb_busy2_set", bus.busy2, 1);
    we = 1'b1; wa = 5'd9; wd = 32'h99;
    #1 check("sb_byp_busy1", bus.busy1, 0);
    step();
    issue_en = 1'b0; we = 1'b0;
    #1;
    check("sb_set_wins", bus.busy1, 1);
    check("sb_rd1", bus.rd1, 32'h99);
    we = 1'b1; wa = 5'd9; wd = 32'h9A;
    #1 check("sb_nb_busy_lone", nb_bus.busy1, 1);
    step();
    we = 1'b0;
    #1;
    check("sb_busy1_clr", bus.busy1, 0);
    check("sb_nb_busy1_clr", nb_bus.busy1, 0);

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = {4{8'(i)}};
      step();
    end
    we = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd3;
    step();
    issue_en = 1'b0; ra1 = 5'd3; ra2 = 5'd31;
    #1;
    check("pre_busy3", bus.busy1, 1);
    check("pre_rd31", bus.rd2, 32'h1F1F_1F1F);

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin we = 1'b1; wa = 5'd4; wd = 32'h0BAD; issue_en = 1'b1; issue_rd = 5'd4; end
      if (c == 6) begin we = 1'b0; issue_en = 1'b0; end
      if (c == 20) clr_req = 1'b1;
      if (c == 21) clr_req = 1'b0;
      if (c == 10) begin ra1 = 5'd2; ra2 = 5'd20; end
      #1;
      check("sweep_clr_busy", bus.clr_busy, (c < 32) ? 1 : 0);
      if (bus.clr_busy) cnt++;
      if (c == 10) begin
        check("sweep_swept_rd", bus.rd1, 0);
        check("sweep_live_rd", bus.rd2, 32'h1414_1414);
      end
      step();
    end
    check("sweep_len", cnt, 32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      check("post_rd1", bus.rd1, 0);
      check("post_busy1", bus.busy1, 0);
      check("post_nb_rd2", nb_bus.rd2, 0);
    end
    ra1 = 5'd4;
    #1 check("sweep_drop_wr4", bus.rd1, 0);

    we = 1'b1; wa = 5'd6; wd = 32'h66;
    step();
    we = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    #1 check("mid_clr_busy", bus.clr_busy, 1);
    reset = 1'b0;
    #1 check("mid_clr_busy_async", bus.clr_busy, 0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      check("mid_rd1", bus.rd1, 0);
      check("mid_busy2", bus.busy2, 0);
    end
    step();
    reset = 1'b1;
    we = 1'b1; wa = 5'd2; wd = 32'h5;
    step();
    we = 1'b0; ra1 = 5'd2; ra2 = 5'd6;
    #1;
    check("after_rst_rd2reg", bus.rd1, 32'h5);
    check("after_rst_reg6", bus.rd2, 0);
    step(); step();
    #1 check("after_rst_idle", bus.clr_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
